wave_pkt_router: RTL and testbench

// - N-channel successor to the fixed two-channel UDP wave path; runs in the GMII receive clock domain.
// - Takes UDP payload bytes plus a one-hot source tag and routes each packet's samples to that

---
 rtl/wave_pkt_router.sv | 221 ++++++++++++++++++++++
 tb/tb_wave_pkt_router.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wave_pkt_router.sv
// Routes UDP wave packets (2-byte frequency header + samples) to per-channel sample FIFOs,
// rejecting packets that would overflow, and publishes per-channel frequency and play enables.
module wave_pkt_router #(
    parameter int CH_NUM    = 2,
    parameter int DW        = 8,
    parameter int CNT_W     = 13,
    parameter int HDR_BYTES = 2,
    parameter int START_LVL = 4096,
    parameter int STOP_LVL  = 0,
    parameter int MARGIN    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rec_en,
    input  logic [7:0]              rec_data,
    input  logic                    rec_pkt_done,
    input  logic [15:0]             rec_byte_num,
    input  logic [CH_NUM-1:0]       wave_source,
    input  logic [CH_NUM*CNT_W-1:0] wr_data_count,
    output logic [CH_NUM-1:0]       wr_en,
    output logic [DW-1:0]           fifo_din,
    output logic [CH_NUM-1:0]       play_en,
    output logic [CH_NUM*16-1:0]    freq,
    output logic [15:0]             drop_cnt
);

    localparam int EXT_W = (CNT_W > 16) ? CNT_W + 2 : 18;
    localparam int SH    = (DW < 8) ? 8 - DW : 0;
    localparam logic [EXT_W-1:0] DEPTH    = EXT_W'(1) << CNT_W;
    localparam logic [EXT_W-1:0] NEED_ADJ = EXT_W'(MARGIN) - EXT_W'(HDR_BYTES);
    localparam logic [CNT_W:0]   START_V  = (CNT_W+1)'(START_LVL);
    localparam logic [CNT_W:0]   STOP_V   = (CNT_W+1)'(STOP_LVL);
    localparam logic             HDR_ONE  = (HDR_BYTES <= 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DROP} state_t;

    state_t              r_state;
    state_t              w_state_byte;
    state_t              w_state_nxt;
    logic                r_skip;
    logic [CH_NUM-1:0]   r_ch;
    logic [15:0]         r_len;
    logic [15:0]         r_hcnt;
    logic [15:0]         r_dcnt;
    logic [15:0]         r_hdr;
    logic [CNT_W-1:0]    w_cnt_sel;
    logic [EXT_W-1:0]    w_free;
    logic [EXT_W-1:0]    w_need;
    logic                w_accept;
    logic [15:0]         w_dlen;
    logic [15:0]         w_hdr_next;
    logic [CH_NUM-1:0]   w_ch_cur;
    logic                w_first;
    logic                w_hdr_shift;
    logic                w_wr;
    logic                w_commit;
    logic                w_drop_inc;
    logic                w_skip_clr;

    function automatic logic f_onehot(input logic [CH_NUM-1:0] v);
        return (v != '0) && ((v & (v - CH_NUM'(1))) == '0);
    endfunction

    function automatic logic [DW-1:0] f_sample(input logic [7:0] b);
        return DW'(b >> SH);
    endfunction

    // Admission check for the packet whose first byte is on the bus.
    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_cnt_sel = w_cnt_sel | (wave_source[i] ? wr_data_count[i*CNT_W +: CNT_W] : '0);
        end
        w_free   = DEPTH - EXT_W'(w_cnt_sel);
        w_need   = EXT_W'(rec_byte_num) + NEED_ADJ;
        w_accept = f_onehot(wave_source) && (rec_byte_num > 16'(HDR_BYTES)) && (w_free >= w_need);
        w_dlen   = r_len - 16'(HDR_BYTES);
        w_ch_cur = w_first ? wave_source : r_ch;
    end

    // Next-state and control: the byte is processed first, then end-of-packet rules apply.
    always_comb begin
        w_state_byte = r_state;
        w_first      = 1'b0;
        w_hdr_shift  = 1'b0;
        w_wr         = 1'b0;
        w_commit     = 1'b0;
        w_drop_inc   = 1'b0;
        w_skip_clr   = 1'b0;
        w_hdr_next   = r_hdr;
        case (r_state)
            S_IDLE: begin
                if (rec_en && !r_skip) begin
                    w_first    = 1'b1;
                    w_hdr_next = {8'h00, rec_data};
                    if (!w_accept) begin
                        w_state_byte = S_DROP;
                    end else if (HDR_ONE) begin
                        w_state_byte = S_DATA;
                    end else begin
                        w_state_byte = S_HDR;
                    end
                end else begin
                    w_state_byte = S_IDLE;
                end
            end
            S_HDR: begin
                if (rec_en) begin
                    w_hdr_shift = 1'b1;
                    w_hdr_next  = {r_hdr[7:0], rec_data};
                    if ((r_hcnt + 16'd1) >= 16'(HDR_BYTES)) begin
                        w_state_byte = S_DATA;
                    end else begin
                        w_state_byte = S_HDR;
                    end
                end else begin
                    w_state_byte = S_HDR;
                end
            end
            S_DATA: begin
                if (rec_en && (r_dcnt < w_dlen)) begin
                    w_wr = 1'b1;
                end else begin
                    w_wr = 1'b0;
                end
            end
            S_DROP: begin
                w_state_byte = S_DROP;
            end
            default: begin
                w_state_byte = S_IDLE;
            end
        endcase

        if (rec_pkt_done) begin
            w_state_nxt = S_IDLE;
            if (r_skip) begin
                w_skip_clr = 1'b1;
            end else if (w_state_byte == S_DATA) begin
                w_commit = 1'b1;
            end else if (w_state_byte != S_IDLE) begin
                w_drop_inc = 1'b1;
            end else begin
                w_drop_inc = 1'b0;
            end
        end else begin
            w_state_nxt = w_state_byte;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Packet context, FIFO write port and published frequency/drop count.
    // After reset the bytes of a packet already in flight are ignored until its end pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip   <= 1'b1;
            r_ch     <= '0;
            r_len    <= 16'd0;
            r_hcnt   <= 16'd0;
            r_dcnt   <= 16'd0;
            r_hdr    <= 16'd0;
            wr_en    <= '0;
            fifo_din <= '0;
            freq     <= '0;
            drop_cnt <= 16'd0;
        end else begin
            wr_en <= w_wr ? r_ch : '0;
            if (w_first) begin
                r_ch   <= wave_source;
                r_len  <= rec_byte_num;
                r_hcnt <= 16'd1;
                r_dcnt <= 16'd0;
            end
            if (w_hdr_shift) begin
                r_hcnt <= r_hcnt + 16'd1;
            end
            r_hdr <= w_hdr_next;
            if (w_wr) begin
                fifo_din <= f_sample(rec_data);
                r_dcnt   <= r_dcnt + 16'd1;
            end
            if (w_commit) begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (w_ch_cur[i]) begin
                        freq[i*16 +: 16] <= w_hdr_next;
                    end
                end
            end
            if (w_drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (w_skip_clr) begin
                r_skip <= 1'b0;
            end
        end
    end

    // Hysteretic play enable per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_en <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if ({1'b0, wr_data_count[i*CNT_W +: CNT_W]} >= START_V) begin
                    play_en[i] <= 1'b1;
                end else if ({1'b0, wr_data_count[i*CNT_W +: CNT_W]} <= STOP_V) begin
                    play_en[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_pkt_router.sv
// Randomized self-checking bench for wave_pkt_router against a packet-level reference model.
module tb_wave_pkt_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic [1:0]  wave_source;
    logic [25:0] wr_data_count;
    logic [1:0]  wr_en;
    logic [7:0]  fifo_din;
    logic [1:0]  play_en;
    logic [31:0] freq;
    logic [15:0] drop_cnt;

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          mskip;
    logic [15:0] mfreq [2];
    int          mdrop;
    logic [1:0]  mplay;

    wave_pkt_router dut (
        .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .rec_data(rec_data),
        .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num), .wave_source(wave_source),
        .wr_data_count(wr_data_count), .wr_en(wr_en), .fifo_din(fifo_din), .play_en(play_en),
        .freq(freq), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        mskip    = 1'b1;
        mfreq[0] = 16'd0;
        mfreq[1] = 16'd0;
        mdrop    = 0;
        mplay    = 2'b00;
    endtask

    // One clock; outputs are checked 1 time unit after the edge.
    task automatic step(input logic [1:0] exp_wr, input logic [7:0] exp_din);
        int c;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            c = int'(wr_data_count[i*13 +: 13]);
            if (c >= 4096) mplay[i] = 1'b1;
            else if (c == 0) mplay[i] = 1'b0;
        end
        #1;
        chk("wr_en", wr_en, exp_wr);
        if (exp_wr != 2'b00) chk("fifo_din", fifo_din, exp_din);
        chk("play_en", play_en, mplay);
    endtask

    task automatic lone_done();
        rec_pkt_done = 1'b1;
        step(2'b00, 8'h00);
        rec_pkt_done = 1'b0;
        mskip = 1'b0;
        chk("lone_done_drop", drop_cnt, 64'(mdrop));
    endtask

    task automatic send_pkt(input logic [1:0] src, input int len, input int nsent,
                            input logic [15:0] fw, input bit coinc, input bit seq,
                            input bit gaps, input int rst_at);
        int   idx;
        int   cnt;
        bit   acc;
        bit   aborted;
        logic [7:0] b;
        idx     = src[1] ? 1 : 0;
        cnt     = int'(wr_data_count[idx*13 +: 13]);
        acc     = !mskip && (src == 2'b01 || src == 2'b10) && len > 2 && (8192 - cnt) >= (len - 2 + 16);
        aborted = 1'b0;
        for (int k = 0; k < nsent; k++) begin
            if (k == rst_at) begin
                rec_en = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("rst_wr_en", wr_en, 2'b00);
                chk("rst_freq", freq, 32'd0);
                chk("rst_drop", drop_cnt, 16'd0);
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
                aborted = 1'b1;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                rec_en       = 1'b0;
                rec_pkt_done = 1'b0;
                step(2'b00, 8'h00);
            end
            if (k == 0)      b = fw[15:8];
            else if (k == 1) b = fw[7:0];
            else if (seq)    b = 8'(k - 2);
            else             b = 8'($urandom);
            rec_en       = 1'b1;
            rec_data     = b;
            rec_byte_num = 16'(len);
            wave_source  = src;
            rec_pkt_done = coinc && (k == nsent - 1);
            step((acc && !aborted && k >= 2 && k < len) ? src : 2'b00, b);
        end
        rec_en       = 1'b0;
        rec_pkt_done = 1'b0;
        if (!coinc) begin
            rec_pkt_done = 1'b1;
            step(2'b00, 8'h00);
            rec_pkt_done = 1'b0;
        end
        if (mskip) mskip = 1'b0;
        else if (acc && nsent >= 2) mfreq[idx] = fw;
        else if (mdrop < 65535) mdrop++;
        chk("freq", freq, {mfreq[1], mfreq[0]});
        chk("drop_cnt", drop_cnt, 64'(mdrop));
        step(2'b00, 8'h00);
    endtask

    initial begin
        int   r;
        int   len;
        int   nsent;
        logic [1:0] src;
        rst_n = 1'b0; rec_en = 1'b0; rec_data = 8'h00; rec_pkt_done = 1'b0;
        rec_byte_num = 16'd0; wave_source = 2'b00; wr_data_count = 26'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_en", wr_en, 2'b00);
        chk("reset_fifo_din", fifo_din, 8'h00);
        chk("reset_play_en", play_en, 2'b00);
        chk("reset_freq", freq, 32'd0);
        chk("reset_drop", drop_cnt, 16'd0);
        rst_n = 1'b1;
        lone_done();

        send_pkt(2'b01, 1026, 1026, 16'h03E8, 1'b0, 1'b1, 1'b0, -1);
        chk("freq0_1000", freq[15:0], 16'd1000);
        send_pkt(2'b10, 40, 40, 16'h1234, 1'b1, 1'b0, 1'b0, -1);
        chk("freq0_kept", freq[15:0], 16'd1000);
        chk("freq1_1234", freq[31:16], 16'h1234);
        send_pkt(2'b11, 20, 20, 16'hAAAA, 1'b0, 1'b0, 1'b0, -1);
        chk("drop_src11", drop_cnt, 16'd1);
        send_pkt(2'b00, 20, 20, 16'hBBBB, 1'b0, 1'b0, 1'b0, -1);
        wr_data_count[12:0] = 13'd8000;
        send_pkt(2'b01, 500, 500, 16'hCCCC, 1'b0, 1'b0, 1'b0, -1);
        chk("drop_full", drop_cnt, 16'd3);

        wr_data_count[12:0] = 13'd0;    step(2'b00, 8'h00);
        chk("play_fall0", play_en[0], 1'b0);
        wr_data_count[12:0] = 13'd4095; step(2'b00, 8'h00);
        chk("play_below", play_en[0], 1'b0);
        wr_data_count[12:0] = 13'd4096; step(2'b00, 8'h00);
        chk("play_rise", play_en[0], 1'b1);
        wr_data_count[12:0] = 13'd1;    step(2'b00, 8'h00);
        chk("play_hold", play_en[0], 1'b1);
        wr_data_count[12:0] = 13'd0;    step(2'b00, 8'h00);
        chk("play_fall", play_en[0], 1'b0);

        send_pkt(2'b01, 100, 1, 16'h0101, 1'b0, 1'b0, 1'b0, -1);
        chk("drop_short_hdr", drop_cnt, 16'd4);
        lone_done();
        send_pkt(2'b01, 200, 200, 16'h5555, 1'b0, 1'b0, 1'b0, 12);
        send_pkt(2'b10, 60, 60, 16'h0777, 1'b0, 1'b0, 1'b0, -1);
        chk("after_rst_freq1", freq[31:16], 16'h0777);
        send_pkt(2'b01, 30, 40, 16'h0202, 1'b1, 1'b0, 1'b0, -1);
        send_pkt(2'b01, 2, 2, 16'h0303, 1'b0, 1'b0, 1'b0, -1);

        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(0, 9);
            src = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 200);
            r = $urandom_range(0, 7);
            if (len < 1)     nsent = 1;
            else if (r == 0) nsent = len + 3;
            else if (r == 1) nsent = $urandom_range(1, len);
            else             nsent = len;
            for (int c = 0; c < 2; c++) begin
                wr_data_count[c*13 +: 13] = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom_range(0, 8191));
            end
            send_pkt(src, len, nsent, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
